fp_result_wb: RTL
=================

FP_RESULT_WB -- requirements
Module: fp_result_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 4: result-queue entries, power of two, 2..16.
REQ-002 SHALL have parameter RD_W, default 5: destination register index width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the FP subtract stage presents a result.
REQ-006 SHALL have port in_ready, output, 1: the queue can accept an entry this cycle.
REQ-007 SHALL have port in_rd, input, RD_W: destination FP register.
REQ-008 SHALL have port in_result, input, 32: IEEE-754 single result.
REQ-009 SHALL have port wb_stall, input, 1: the FP register-file write port is unavailable this cycle.
REQ-010 SHALL have port wb_en, output, 1: register-file write strobe.
REQ-011 SHALL have port wb_rd, output, RD_W: write address.
REQ-012 SHALL have port wb_data, output, 32: write data.
REQ-013 SHALL have port fflags_clr, input, 1: clear the sticky flags (CSR write).
REQ-014 SHALL have port fflags, output, 5: sticky {NV,DZ,OF,UF,NX}.
REQ-015 SHALL have port occupancy, output, $clog2(DEPTH)+1: entries held.

Function
REQ-016 SHALL drive in_ready = (occupancy != DEPTH), combinationally from registered state only.
REQ-017 SHALL push {in_rd,in_result} at a posedge where in_valid && in_ready; in_valid while full is held off and nothing is written.
REQ-018 SHALL pop the head at a posedge where occupancy != 0 && !wb_stall.
REQ-019 SHALL register the popped entry so that wb_en=1, wb_rd, wb_data appear in the cycle after the pop edge; otherwise wb_en=0, and wb_rd/wb_data hold their last values.
REQ-020 SHALL have a minimum latency of 2 edges into an empty queue: push at edge N, pop at N+1, wb_en high during cycle N+1..N+2; no bypass path.
REQ-021 SHALL, on simultaneous push and pop, keep occupancy unchanged and store the new entry behind the remaining entries; with occupancy==DEPTH, the push is still blocked by REQ-016.
REQ-022 SHALL preserve strict FIFO order; read/write pointers wrap modulo DEPTH.
REQ-023 SHALL classify each entry at pop: NV if exp==0xFF && mant!=0; OF if exp==0xFF && mant==0; UF if exp==0x00 && mant!=0; DZ and NX are always 0 (the subtract stage does not produce them).
REQ-024 SHALL OR the popped entry's flags into fflags at the pop edge.
REQ-025 SHALL clear fflags on fflags_clr; with fflags_clr and a pop on the same edge, fflags = flags of that popped entry only.
REQ-026 SHALL write every rd including 0 (f0 is architectural).
REQ-027 SHALL leave the queue unaffected by wb_stall, except that the pop is blocked.

Reset
REQ-028 SHALL, while reset=1 at posedge, set occupancy=0, pointers=0, wb_en=0, wb_rd=0, wb_data=0x00000000, fflags=0; in_ready therefore reads 1 the cycle after reset.
REQ-029 SHALL discard queued entries on reset mid-operation; no wb_en is issued for them, and in_valid is ignored during the reset cycle.

Structure
REQ-030 SHALL place FP_EXP_MAX=8'hFF, the flag bit indices (NV=4,DZ=3,OF=2,UF=1,NX=0) and the flag-vector typedef in shared package fp_pkg.
REQ-031 SHALL implement the storage as one sub-module, fp_wb_fifo (parameterised sync FIFO with push/pop/full/empty/count); classification, flag and write-port logic stay in fp_result_wb.

Verification
REQ-032 SHALL cover the single result case: push rd=3, 0x3F800000 into an empty queue with wb_stall=0 -> wb_en=1, wb_rd=3, wb_data=0x3F800000 exactly 2 edges later, fflags=0.
REQ-033 SHALL cover the full queue case: wb_stall=1 with 5 pushes attempted (DEPTH=4) -> in_ready=0 after the 4th push and the 5th is held; release the stall -> 4 writes in order on consecutive cycles, then the 5th.
REQ-034 SHALL cover flag accumulation: pop 0x7F800000, then 0x7FC00000, then 0x00000001 -> fflags=5'b00100, then 5'b10100, then 5'b10110; fflags_clr with a pop of 0x00400000 on the same edge -> 5'b00010.
REQ-035 SHALL cover simultaneous push and pop at occupancy=2 -> occupancy stays 2 and order is preserved.
REQ-036 SHALL cover reset mid-operation: reset with 3 entries queued -> occupancy=0, no wb_en afterwards, fflags=0, in_ready=1.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP constants, sticky-flag layout and result classification
package fp_pkg;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef logic [4:0] fflags_t;
  // Subtract results never raise DZ or NX, so only the exponent/mantissa shape matters
  function automatic fflags_t fp_classify(input logic [31:0] v);
    fflags_t f;
    logic [7:0] e;
    logic mz;
    e = v[30:23];
    mz = v[22:0] == 23'd0;
    f = '0;
    f[FLAG_NV] = e == FP_EXP_MAX && !mz;
    f[FLAG_DZ] = 1'b0;
    f[FLAG_OF] = e == FP_EXP_MAX && mz;
    f[FLAG_UF] = e == 8'h00 && !mz;
    f[FLAG_NX] = 1'b0;
    return f;
  endfunction
endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo: parameterised synchronous FIFO with registered occupancy count
module fp_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (do_push && !reset) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fp_result_wb.sv
// fp_result_wb: FP result queue draining into the register-file write port with sticky flags
module fp_result_wb
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RD_W-1:0]        in_rd,
  input  logic [31:0]            in_result,
  input  logic                   wb_stall,
  output logic                   wb_en,
  output logic [RD_W-1:0]        wb_rd,
  output logic [31:0]            wb_data,
  input  logic                   fflags_clr,
  output fflags_t                fflags,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int W = RD_W + 32;
  logic full, empty, pop;
  logic [W-1:0] head;
  fflags_t pop_flags;
  assign in_ready = !full;
  assign pop = !empty && !wb_stall;
  assign pop_flags = pop ? fp_classify(head[31:0]) : '0;
  fp_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(in_valid),
    .pop(pop),
    .din({in_rd, in_result}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
  // A clear on a popping edge keeps only that entry's flags
  always_ff @(posedge clk)
    if (reset) begin
      wb_en <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      fflags <= '0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_rd <= head[W-1:32];
        wb_data <= head[31:0];
      end
      fflags <= (fflags_clr ? '0 : fflags) | pop_flags;
    end
endmodule
